// File: rtl/output_sel_ctrl_pkg.sv
// Shared types for the output selector sequencer: FSM states, request modes
// and source codes, plus small mode/source mapping helpers.
package output_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RUN_DFE = 2'd1,
        RUN_TEG = 2'd2,
        GAP     = 2'd3
    } state_e;

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_DFE = 2'b01;
    localparam logic [1:0] MODE_TEG = 2'b10;
    localparam logic [1:0] MODE_ALT = 2'b11;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_DFE  = 2'b01;
    localparam logic [1:0] SRC_TEG  = 2'b10;

    // Alternate mode keeps whatever source is running; from idle it starts on DFE.
    function automatic logic [1:0] req_src(input logic [1:0] mode, input logic [1:0] cur);
        logic [1:0] s;
        case (mode)
            MODE_DFE: s = SRC_DFE;
            MODE_TEG: s = SRC_TEG;
            MODE_ALT: s = (cur == SRC_NONE) ? SRC_DFE : cur;
            default:  s = SRC_NONE;
        endcase
        return s;
    endfunction

    function automatic state_e src_state(input logic [1:0] src);
        state_e st;
        case (src)
            SRC_DFE: st = RUN_DFE;
            SRC_TEG: st = RUN_TEG;
            default: st = OFF;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/output_sel_ctrl_timer.sv
// Loadable down-counter with zero flag; times the blanking gap between sources.
module output_sel_ctrl_timer
    import output_sel_ctrl_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/output_sel_ctrl.sv
// Sequencer for the DFE / ADC-TEG output selector enables with a blanking gap on
// every switch. Define OUTPUT_SEL_CTRL_ALT_EN to build frame-based alternation.
module output_sel_ctrl
    import output_sel_ctrl_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int FRAME_LEN  = 256,
    parameter int CW         = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    input  logic [1:0]    mode_req_i,
    output logic          req_ready_o,
    output logic          enable_dfe_o,
    output logic          enable_adc_teg_o,
    output logic [1:0]    active_src_o,
    output logic          switch_done_o,
    output logic [CW-1:0] frame_cnt_o
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e     state_q, state_d;
    logic [1:0] tgt_q, tgt_d;
    logic       en_dfe_q, en_teg_q, done_q;
    logic [1:0] act_q;
    logic       accept, gap_zero, gap_load, alt_expire;
    logic [1:0] eff_mode, cur_src, new_src;

    assign req_ready_o = !rst_i && (state_q != GAP);
    assign accept      = req_valid_i && req_ready_o;

    assign cur_src = (state_q == RUN_DFE) ? SRC_DFE :
                     (state_q == RUN_TEG) ? SRC_TEG : SRC_NONE;

`ifdef OUTPUT_SEL_CTRL_ALT_EN
    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;

    assign eff_mode = mode_req_i;

    always_comb begin
        mode_d = mode_q;
        if (accept) mode_d = eff_mode;
    end

    // Request in the expiry cycle updates mode_d first, so a mode change wins.
    assign alt_expire = (mode_d == MODE_ALT) && (frame_cnt_q >= CW'(FRAME_LEN - 1));

    always_comb begin
        frame_cnt_d = '0;
        if (state_d == RUN_DFE || state_d == RUN_TEG) begin
            if (state_d == state_q)
                frame_cnt_d = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q      <= MODE_OFF;
            frame_cnt_q <= '0;
        end else begin
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`else
    assign eff_mode    = (mode_req_i == MODE_ALT) ? MODE_OFF : mode_req_i;
    assign alt_expire  = 1'b0;
    assign frame_cnt_o = '0;
`endif

    assign new_src = req_src(eff_mode, cur_src);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        case (state_q)
            OFF: begin
                if (accept && new_src != SRC_NONE) state_d = src_state(new_src);
            end
            RUN_DFE, RUN_TEG: begin
                if (accept && new_src != cur_src) begin
                    state_d = GAP;
                    tgt_d   = new_src;
                end else if (alt_expire) begin
                    state_d = GAP;
                    tgt_d   = (cur_src == SRC_DFE) ? SRC_TEG : SRC_DFE;
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_d = src_state(tgt_q);
                    tgt_d   = SRC_NONE;
                end
            end
            default: state_d = OFF;
        endcase
    end

    assign gap_load = (state_d == GAP) && (state_q != GAP);

    output_sel_ctrl_timer #(.W(GW)) u_gap_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (gap_load),
        .en_i       (state_q == GAP),
        .load_val_i (GW'(GAP_CYCLES - 1)),
        .zero_o     (gap_zero)
    );

    // Outputs are flopped from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= OFF;
            tgt_q    <= SRC_NONE;
            en_dfe_q <= 1'b0;
            en_teg_q <= 1'b0;
            act_q    <= SRC_NONE;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            en_dfe_q <= (state_d == RUN_DFE);
            en_teg_q <= (state_d == RUN_TEG);
            act_q    <= (state_d == RUN_DFE) ? SRC_DFE :
                        (state_d == RUN_TEG) ? SRC_TEG : SRC_NONE;
            done_q   <= (state_d != state_q) && (state_d != GAP);
        end
    end

    assign enable_dfe_o     = en_dfe_q;
    assign enable_adc_teg_o = en_teg_q;
    assign active_src_o     = act_q;
    assign switch_done_o    = done_q;

endmodule
